bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Round-robin arbiter directly upstream of the bus mux. Turns COUNT per-source
//   request lines into the one-hot enable vector that selects the bus driver.
//   Guarantees at most one driver, a one-cycle dead gap between owners, and a
//   hold limit so that no source can starve the others.
// PARAMETERS
//   COUNT     4  number of bus sources (>=2); equals COUNT of the bus mux
//   MAX_HOLD  8  max consecutive cycles per grant; 0 = unlimited
//   IDXW      $clog2(COUNT) (localparam) width of the owner index
// PORTS
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       synchronous reset, active-low
//   req      in   COUNT   request per source; held high until the transfer is done
//   enable   out  COUNT   one-hot (or zero) drive select; connects to bus enable
//   owner    out  IDXW    index of the current grantee; valid while busy=1
//   busy     out  1       1 while any enable bit is high
//   preempt  out  1       1-cycle pulse: grant ended by hold limit with req still high
// BEHAVIOUR
//   - All outputs are registered. Reset (rst_n=0 at a clk edge): enable=0,
//     owner=0, busy=0, preempt=0, state=IDLE, rr pointer=0, hold_cnt=0.
//   - States: IDLE -> GRANT -> GAP -> (GRANT | IDLE).
//   - Pick: the first set req bit searching from ptr upward, wrapping at COUNT-1 to 0.
//   - IDLE: if req!=0 at edge N, then at N+1 enable=1<<pick, owner=pick, busy=1,
//     hold_cnt=1, ptr=(pick+1) mod COUNT, state=GRANT. Latency req->enable = 1 clk.
//   - GRANT: at each edge where req[owner]=0, OR MAX_HOLD!=0 && hold_cnt==MAX_HOLD:
//     enable=0, busy=0, state=GAP. If the release came from the limit while
//     req[owner]=1, preempt=1 for that one cycle. Otherwise hold_cnt++.
//     hold_cnt saturates; it never wraps when MAX_HOLD=0.
//   - GAP: exactly one cycle with enable=0. At the end, pick on current req:
//     req!=0 -> GRANT as from IDLE; req==0 -> IDLE.
//   - Preempted source: keeps its req; it is re-served only after every other
//     requester, because ptr has moved past it.
//   - Requests rising or falling during GAP or GRANT for non-owners:
//     - have no effect until the next pick;
//     - no grant is given to a source whose req is low at pick time.
//   - Only req[owner] can end a grant. Other req changes never change enable
//     mid-grant.
//   - enable is never multi-hot. Going directly from one owner to another
//     without a zero cycle is forbidden.
//   - rst_n low mid-grant: enable drops at that same edge; ptr returns to 0.
//   - owner holds its last value while busy=0, except after reset, when it is 0.
// TESTING
//   1 Reset: rst_n=0 for 2 clk with req=4'b1111 -> enable=0, busy=0, preempt=0
//     throughout.
//   2 Single request: req=4'b0100 from edge N, dropped after 3 grant cycles ->
//     enable=4'b0100 for cycles N+1..N+3, then 0; owner=2; preempt never pulses.
//   3 Round-robin: req=4'b1111 held, MAX_HOLD=8 -> grant order idx 0,1,2,3,0;
//     each grant lasts 8 cycles with 1 gap cycle between; preempt pulses at
//     every release.
//   4 Wrap and skip: ptr=3 with req=4'b0011 -> idx0 served, then idx1; idx2 and
//     idx3 are never enabled.
//   5 Late requester: idx1 owns the bus; req[3] rises mid-grant -> enable stays
//     4'b0010 until req[1] falls; one zero cycle; then 4'b1000.
//   6 Reset mid-grant: rst_n=0 while enable=4'b0010 -> enable=0 at that edge;
//     after release with req=4'b0110 -> idx1 granted first (ptr=0).
//   All scenarios: a checker asserts $onehot0(enable) every cycle, that busy
//   equals |enable, and that at least one zero cycle occurs between owners.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake bundle: per-source requests in, one-hot enable out.
interface bus_arbiter_if #(
    parameter int unsigned COUNT = 4
);
    localparam int unsigned IDXW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [COUNT-1:0] req;
    logic [COUNT-1:0] enable;
    logic [IDXW-1:0]  owner;
    logic             busy;
    logic             preempt;

    // Arbiter side
    modport master (
        input  req,
        output enable,
        output owner,
        output busy,
        output preempt
    );

    // Requesting / observing side
    modport slave (
        output req,
        input  enable,
        input  owner,
        input  busy,
        input  preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a mandatory dead cycle between owners and a
// per-grant hold limit so no source can starve the others.
module bus_arbiter #(
    parameter int unsigned COUNT    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);
    localparam int unsigned IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1;
    // Wide enough to reach MAX_HOLD and saturate above it; 1 bit when unlimited.
    localparam int unsigned HOLDW = $clog2(MAX_HOLD + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [COUNT-1:0]  enable_q, enable_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [HOLDW-1:0]  hold_q, hold_d;

    logic              pick_valid_c;
    logic [IDXW-1:0]   pick_idx_c;
    logic              limit_c;
    logic              owner_req_c;

    // Index a + off, wrapped into 0..COUNT-1 (off is always < COUNT here).
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] a,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(a) + off;
        if (s >= COUNT) begin
            s = s - COUNT;
        end
        return IDXW'(s);
    endfunction

    // First set request at or above ptr, wrapping around.
    always_comb begin
        logic [IDXW-1:0] cand;
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        cand         = '0;
        for (int unsigned off = 0; off < COUNT; off++) begin
            cand = wrap_add(ptr_q, off);
            if (!pick_valid_c && bus.req[cand]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = cand;
            end
        end
    end

    assign limit_c     = (MAX_HOLD != 0) && (hold_q == HOLDW'(MAX_HOLD));
    assign owner_req_c = bus.req[owner_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_valid_c) begin
                    state_d  = ST_GRANT;
                    enable_d = COUNT'(1) << pick_idx_c;
                    owner_d  = pick_idx_c;
                    busy_d   = 1'b1;
                    hold_d   = HOLDW'(1);
                    ptr_d    = wrap_add(pick_idx_c, 1);
                end else begin
                    state_d  = ST_IDLE;
                    enable_d = '0;
                    busy_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!owner_req_c || limit_c) begin
                    state_d   = ST_GAP;
                    enable_d  = '0;
                    busy_d    = 1'b0;
                    preempt_d = limit_c && owner_req_c;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLDW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            enable_q  <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.enable  = enable_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (COUNT=4, MAX_HOLD=8).
module tb_bus_arbiter;
    logic clk;
    logic rst_n;

    bus_arbiter_if #(.COUNT(4)) bif ();

    bus_arbiter #(.COUNT(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] en;
        logic       busy;
        logic [1:0] owner;
        logic       pre;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         step_no = 0;
    logic [3:0] prev_en = 4'b0;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] e,
                                input logic b, input logic [1:0] o, input logic p);
        vec_t v;
        v.rst_n = r; v.req = rq; v.en = e; v.busy = b; v.owner = o; v.pre = p;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, step_no, act, want);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        rst_n   = v.rst_n;
        bif.req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp("enable",  32'(bif.enable),  32'(e.en));
        cmp("busy",    32'(bif.busy),    32'(e.busy));
        cmp("owner",   32'(bif.owner),   32'(e.owner));
        cmp("preempt", 32'(bif.preempt), 32'(e.pre));
        cmp("onehot0", 32'($onehot0(bif.enable)), 32'd1);
        cmp("busy_eq_or", 32'(bif.busy), 32'(|bif.enable));
        cmp("dead_gap", 32'((prev_en != 4'b0) && (bif.enable != 4'b0) && (bif.enable != prev_en)), 32'd0);
        prev_en = bif.enable;
        step_no++;
    endtask

    initial begin
        rst_n   = 1'b0;
        bif.req = 4'b0;

        // Reset held with all requests high
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd0, 0));
        // Single request idx2 for three grant cycles, no preempt
        vecs.push_back(mk(1, 4'h4, 4'h4, 1, 2'd2, 0));
        vecs.push_back(mk(1, 4'h4, 4'h4, 1, 2'd2, 0));
        vecs.push_back(mk(1, 4'h4, 4'h4, 1, 2'd2, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd2, 0));
        // ptr=3, req=0011: wrap to idx0, then idx1
        vecs.push_back(mk(1, 4'h3, 4'h1, 1, 2'd0, 0));
        vecs.push_back(mk(1, 4'h3, 4'h1, 1, 2'd0, 0));
        vecs.push_back(mk(1, 4'h2, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 4'h2, 4'h2, 1, 2'd1, 0));
        // Late requester idx3 rises mid-grant of idx1
        vecs.push_back(mk(1, 4'hA, 4'h2, 1, 2'd1, 0));
        vecs.push_back(mk(1, 4'hA, 4'h2, 1, 2'd1, 0));
        vecs.push_back(mk(1, 4'h8, 4'h0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 4'h8, 4'h8, 1, 2'd3, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd3, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd3, 0));
        // Reset mid-grant, then ptr restarts at 0
        vecs.push_back(mk(1, 4'h2, 4'h2, 1, 2'd1, 0));
        vecs.push_back(mk(1, 4'h2, 4'h2, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'h2, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mk(1, 4'h6, 4'h2, 1, 2'd1, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 4'hF, 4'h0, 0, 2'd0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // All requesting: 8-cycle grants 0,1,2,3,0 each ended by a preempt gap
        for (int g = 0; g < 5; g++) begin
            logic [1:0] k;
            k = 2'(g % 4);
            for (int c = 0; c < 8; c++) begin
                apply(mk(1, 4'hF, 4'(1) << k, 1, k, 0));
            end
            apply(mk(1, 4'hF, 4'h0, 0, k, 1));
        end
        apply(mk(1, 4'h0, 4'h0, 0, 2'd0, 0));
        apply(mk(1, 4'h0, 4'h0, 0, 2'd0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
